// File: rtl/frame_fifo_burst_writer_pkg.sv
// Shared definitions for the frame FIFO / DDR3 burst engines: FSM encodings and bit constants.
package frame_fifo_burst_writer_pkg;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    localparam int unsigned REQ_SYNC_STAGES = 3;

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_ACK             = 3'd1,
        S_CHECK_FIFO      = 3'd2,
        S_WRITE_BURST     = 3'd3,
        S_WRITE_BURST_END = 3'd4,
        S_END             = 3'd5
    } state_t;

endpackage

// File: rtl/frame_fifo_burst_writer_sync_bits.sv
// N-flop single-bit synchroniser into the clk domain; q is the last stage.
module frame_fifo_burst_writer_sync_bits #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/frame_fifo_burst_writer.sv
// Drains the capture-side write FIFO into memory as a sequence of burst write requests, one frame per
// write_req handshake; the last burst of a frame is shortened to the words remaining.
module frame_fifo_burst_writer
    import frame_fifo_burst_writer_pkg::*;
#(
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned ADDR_BITS     = 23,
    parameter int unsigned BURST_BITS    = 10,
    parameter int unsigned BURST_SIZE    = 128
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    output logic                  wr_burst_req,
    output logic [BURST_BITS-1:0] wr_burst_len,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    output logic                  fifo_rden,
    output logic                  fifo_aclr,
    input  logic [15:0]           rdusedw,
    input  logic                  write_req,
    output logic                  write_req_ack,
    output logic                  write_finish,
    input  logic [ADDR_BITS-1:0]  write_addr_0,
    input  logic [ADDR_BITS-1:0]  write_addr_1,
    input  logic [ADDR_BITS-1:0]  write_addr_2,
    input  logic [ADDR_BITS-1:0]  write_addr_3,
    input  logic [1:0]            write_addr_index,
    input  logic [ADDR_BITS-1:0]  write_len,
    output logic                  over_req
);

    if (MEM_DATA_BITS < 1 || BURST_SIZE < 1 || BURST_SIZE > (2**BURST_BITS) - 1) begin : g_bad_params
        $error("frame_fifo_burst_writer: illegal parameter combination");
    end

    state_t                 state;
    logic                   req_d2;
    logic [ADDR_BITS-1:0]   len_d0;
    logic [ADDR_BITS-1:0]   len_d1;
    logic [1:0]             index_d0;
    logic [1:0]             index_d1;
    logic [ADDR_BITS-1:0]   len_latch;
    logic [ADDR_BITS-1:0]   write_cnt;
    logic [BURST_BITS-1:0]  beat_cnt;
    logic [ADDR_BITS-1:0]   remain;
    logic [ADDR_BITS-1:0]   blen_full;
    logic [BURST_BITS-1:0]  blen;
    logic [ADDR_BITS-1:0]   base_sel;
    logic                   beat_ok;

    frame_fifo_burst_writer_sync_bits #(
        .STAGES (REQ_SYNC_STAGES)
    ) u_req_sync (
        .clk (mem_clk),
        .rst (rst),
        .d   (write_req),
        .q   (req_d2)
    );

    // Frame length and buffer select cross with two flops; they are stable long before req_d2 rises.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            len_d0   <= '0;
            len_d1   <= '0;
            index_d0 <= '0;
            index_d1 <= '0;
        end else begin
            len_d0   <= write_len;
            len_d1   <= len_d0;
            index_d0 <= write_addr_index;
            index_d1 <= index_d0;
        end
    end

    always_comb begin
        base_sel = write_addr_0;
        case (index_d1)
            2'd0:    base_sel = write_addr_0;
            2'd1:    base_sel = write_addr_1;
            2'd2:    base_sel = write_addr_2;
            default: base_sel = write_addr_3;
        endcase
    end

    // Next burst length: a full burst, or whatever is left of the frame.
    assign remain    = len_latch - write_cnt;
    assign blen_full = (remain > ADDR_BITS'(BURST_SIZE)) ? ADDR_BITS'(BURST_SIZE) : remain;
    assign blen      = BURST_BITS'(blen_full);

    // FIFO read must land in the same cycle the controller asks for the word.
    assign beat_ok   = beat_cnt < wr_burst_len;
    assign fifo_rden = (state == S_WRITE_BURST) && wr_burst_data_req && beat_ok;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_burst_req  <= ZERO;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            fifo_aclr     <= ZERO;
            write_req_ack <= ZERO;
            write_finish  <= ZERO;
            over_req      <= ZERO;
            len_latch     <= '0;
            write_cnt     <= '0;
            beat_cnt      <= '0;
        end else begin
            write_finish <= ZERO;
            case (state)
                S_IDLE: begin
                    write_req_ack <= ZERO;
                    if (req_d2) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (req_d2) begin
                        write_req_ack <= ONE;
                        fifo_aclr     <= ONE;
                        wr_burst_addr <= base_sel;
                        len_latch     <= len_d1;
                        write_cnt     <= '0;
                        over_req      <= ZERO;
                    end else begin
                        write_req_ack <= ZERO;
                        fifo_aclr     <= ZERO;
                        state         <= S_CHECK_FIFO;
                    end
                end
                S_CHECK_FIFO: begin
                    if (req_d2) begin
                        state <= S_ACK;
                    end else if (write_cnt >= len_latch) begin
                        state        <= S_END;
                        write_finish <= ONE;
                    end else if (rdusedw >= 16'(blen)) begin
                        wr_burst_len <= blen;
                        wr_burst_req <= ONE;
                        beat_cnt     <= '0;
                        state        <= S_WRITE_BURST;
                    end
                end
                S_WRITE_BURST: begin
                    if (wr_burst_data_req) begin
                        wr_burst_req <= ZERO;
                        if (beat_ok) begin
                            beat_cnt <= beat_cnt + BURST_BITS'(1);
                        end else begin
                            over_req <= ONE;
                        end
                    end
                    // A burst always runs to the controller's finish; frame requests wait.
                    if (wr_burst_finish) begin
                        write_cnt     <= write_cnt + ADDR_BITS'(wr_burst_len);
                        wr_burst_addr <= wr_burst_addr + ADDR_BITS'(wr_burst_len);
                        state         <= S_WRITE_BURST_END;
                    end
                end
                S_WRITE_BURST_END: begin
                    if (req_d2) begin
                        state <= S_ACK;
                    end else if (write_cnt < len_latch) begin
                        state <= S_CHECK_FIFO;
                    end else begin
                        state        <= S_END;
                        write_finish <= ONE;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
